mux151_scan_capture: RTL
========================

// Module: mux151_scan_capture
// PURPOSE
//   Sequencer/capture stage around one 74LS151 8:1 mux model. Drives the
//   mux select and strobe pins, samples Y/W for all 8 addresses and
//   assembles an 8-bit word.
//   Used on the TTL sim board to read back an 8-line bus serially through a
//   single '151, as flag readback does. A start/busy/done handshake lets
//   control logic trigger a scan.
// PARAMETERS
//   SETTLE_CYCLES  1  wait cycles after each select change before sampling.
//                     Models TTL propagation. Legal range 0..15.
//   CHECK_W        1  1 = compare W against ~Y on every sample and flag a
//                     mismatch on err.
// PORTS
//   clk         in   1  single clock; all state changes on the rising edge
//   rst         in   1  synchronous, active-high reset
//   start       in   1  request a scan; sampled only in IDLE
//   mux_sel     out  3  select to mux: [0]=A (pin 11), [1]=B (pin 10), [2]=C (pin 9)
//   mux_strobe  out  1  to mux strobe (pin 7); 1 = disabled, Y forced high
//   mux_y       in   1  mux Y (pin 5)
//   mux_w       in   1  mux W (pin 6), expected ~Y
//   busy        out  1  high from the start acceptance until DONE ends
//   done        out  1  one-cycle pulse: data/err are valid
//   data        out  8  captured word; data[i] = Y sampled with sel=i
//   err         out  1  W==Y seen during last scan (CHECK_W=1 only)
// BEHAVIOUR
//   Reset: state=IDLE, mux_sel=0, mux_strobe=1, busy=0, done=0, data=0,
//     err=0, shadow=0, wait counter=0.
//     Reset wins over every other input, including mid-scan; no done pulse
//     on abort.
//   States:
//   - IDLE: strobe=1, sel=0. On start=1: go to SETTLE (SAMPLE if
//     SETTLE_CYCLES=0); strobe=0, sel=0, clear shadow and err_acc, load
//     wait counter.
//   - SETTLE: hold sel, strobe=0. Stay exactly SETTLE_CYCLES cycles
//     (4-bit down-counter), then go to SAMPLE.
//   - SAMPLE: one cycle. shadow[sel] <= mux_y. If CHECK_W and mux_w==mux_y,
//     err_acc <= 1.
//     If sel==7, go to DONE. Else sel<=sel+1, reload counter, go to SETTLE
//     (or SAMPLE directly when SETTLE_CYCLES=0).
//   - DONE: one cycle. done=1, strobe=1, sel=0; data<=shadow and err<=err_acc
//     take effect at DONE entry. Then go to IDLE.
//   busy=1 in SETTLE, SAMPLE and DONE.
//   Timing: start sampled at edge k; DONE is entered at edge k+8*(S+1) with
//     S=SETTLE_CYCLES. Example: S=1 gives done high for the cycle after edge
//     k+16.
//   data/err hold their value until the next DONE or reset; they never change
//     mid-scan.
//   start is ignored while busy, including the DONE cycle. start held high
//     gives back-to-back scans with one IDLE cycle between them.
//   sel counts 0..7 and never wraps inside a scan; it returns to 0 in
//     DONE/IDLE.
//   X/Z on mux_y is captured as-is; no filtering.
// TESTING
//   - rst=1 for 2 cycles -> mux_strobe=1, mux_sel=0, busy=0, done=0, data=0x00, err=0.
//   - Connect a '151 model with D7..D0=0xA5 and pulse start (S=1) -> done at
//     start+16 edges, data=0xA5, err=0, exactly one done pulse.
//   - S=0, D=0x3C -> done at start+8 edges, data=0x3C. sel sequence observed
//     as 0,1,...,7 on consecutive cycles.
//   - Pulse start again while busy mid-scan -> ignored, one done only.
//     Hold start high -> second scan begins after exactly 1 IDLE cycle.
//   - Tie mux_w=mux_y during sel=3 only -> err=1 at done, data is still
//     correct. The next clean scan -> err=0.
//   - Assert rst at sel=4 of a scan following a prior 0xFF result -> IDLE
//     next cycle, data=0x00, no done. A new start gives a full correct scan.

Source files
------------

// File: rtl/mux151_scan_capture_if.sv
// Bus between the scan sequencer and its surroundings: the start/busy/done
// handshake, the captured result, and the pins of the single '151 mux.
interface mux151_scan_capture_if;
  // Handshake: start is sampled only while busy is low, and a high sample
  // launches one scan. busy stays high from that edge until the done cycle
  // ends. done is a one-cycle pulse, and data/err are valid in that cycle.
  // data/err then hold until the next done or reset.
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] data;
  logic       err;
  logic [2:0] mux_sel;
  logic       mux_strobe;
  logic       mux_y;
  logic       mux_w;

  modport master (
    output start, mux_y, mux_w,
    input  busy, done, data, err, mux_sel, mux_strobe
  );

  modport slave (
    input  start, mux_y, mux_w,
    output busy, done, data, err, mux_sel, mux_strobe
  );
endinterface

// File: rtl/mux151_scan_capture.sv
// Walks one 74LS151 through all eight addresses, waits SETTLE_CYCLES after
// each select change, samples Y (and checks W against ~Y), then presents the word.
module mux151_scan_capture #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter bit          CHECK_W       = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  mux151_scan_capture_if.slave     bus,
  output logic [1:0]               dbg_state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam bit         NO_SETTLE = (SETTLE_CYCLES == 0);

  logic [1:0] state;
  logic [2:0] sel;
  logic [3:0] cnt;
  logic [7:0] shadow;
  logic       err_acc;
  logic [7:0] data_q;
  logic       err_q;

  logic [7:0] shadow_nx;
  logic       samp_mis;

  // The word including the bit being sampled this cycle, so the last
  // sample can be published at DONE entry without an extra cycle.
  always_comb begin
    shadow_nx      = shadow;
    shadow_nx[sel] = bus.mux_y;
  end

  assign samp_mis = CHECK_W && (bus.mux_w == bus.mux_y);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      sel     <= 3'd0;
      cnt     <= 4'd0;
      shadow  <= 8'h00;
      err_acc <= 1'b0;
      data_q  <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          sel <= 3'd0;
          if (bus.start) begin
            shadow  <= 8'h00;
            err_acc <= 1'b0;
            cnt     <= SETTLE_LD;
            state   <= NO_SETTLE ? ST_SAMPLE : ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          // cnt was loaded with SETTLE_CYCLES, so leaving at 1 gives exactly that many cycles here.
          if (cnt <= 4'd1) state <= ST_SAMPLE;
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        ST_SAMPLE: begin
          shadow  <= shadow_nx;
          err_acc <= err_acc | samp_mis;
          if (sel == 3'd7) begin
            sel    <= 3'd0;
            data_q <= shadow_nx;
            err_q  <= err_acc | samp_mis;
            state  <= ST_DONE;
          end else begin
            sel   <= sel + 3'd1;
            cnt   <= SETTLE_LD;
            state <= NO_SETTLE ? ST_SAMPLE : ST_SETTLE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mux_sel    = sel;
  assign bus.mux_strobe = (state == ST_IDLE) || (state == ST_DONE);
  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = (state == ST_DONE);
  assign bus.data       = data_q;
  assign bus.err        = err_q;
  assign dbg_state      = state;

endmodule
